// File: rtl/cdc_in_scheduler.sv
// rtl/cdc_in_scheduler.sv - bulk-IN packet scheduler for CDC data channels sharing one endpoint path
module cdc_in_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int MAX_PKT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_req,
  input  logic [1:0]  in_ep,
  input  logic [3:0]  ch_valid,
  input  logic [31:0] ch_data,
  output logic [3:0]  ch_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_eop,
  output logic        tx_nak,
  output logic        busy,
  output logic [3:0]  zlp_pend
);

  typedef enum logic [1:0] {IDLE, SEND, EOP, NAK} state_t;

  state_t     state, state_nxt;
  logic [1:0] sel;
  logic [6:0] cnt;
  logic       ep_ok;
  logic       sel_valid;
  logic       accept;
  logic       last_byte;

  assign ep_ok     = ({30'd0, in_ep} < NUM_CH);
  assign sel_valid = ch_valid[sel];
  assign accept    = (state == SEND) && sel_valid && tx_ready;
  assign last_byte = (cnt == 7'(MAX_PKT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'd0;
    ch_ready  = 4'd0;
    tx_eop    = 1'b0;
    tx_nak    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (in_req) begin
          if (!ep_ok)                 state_nxt = NAK;
          else if (ch_valid[in_ep])   state_nxt = SEND;
          else if (zlp_pend[in_ep])   state_nxt = EOP;
          else                        state_nxt = NAK;
        end
      end
      SEND: begin
        tx_valid      = sel_valid;
        tx_data       = ch_data[{sel, 3'b000} +: 8];
        ch_ready[sel] = tx_ready;
        // An empty FIFO ends the packet short; the MAX_PKT-th byte ends it full.
        if (!sel_valid)              state_nxt = EOP;
        else if (accept && last_byte) state_nxt = EOP;
      end
      EOP: begin
        tx_eop    = 1'b1;
        state_nxt = IDLE;
      end
      NAK: begin
        tx_nak    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= 2'd0;
      cnt      <= 7'd0;
      zlp_pend <= 4'd0;
    end else if (state == IDLE) begin
      // Starting a packet or sending the owed ZLP both settle the channel's ZLP debt.
      if (in_req && ep_ok) begin
        zlp_pend[in_ep] <= 1'b0;
        if (ch_valid[in_ep]) begin
          sel <= in_ep;
          cnt <= 7'd0;
        end
      end
    end else if (state == SEND) begin
      if (!sel_valid) begin
        zlp_pend[sel] <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + 7'd1;
        if (last_byte) zlp_pend[sel] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_in_scheduler.sv
// tb/tb_cdc_in_scheduler.sv - directed scoreboard bench for cdc_in_scheduler
module tb_cdc_in_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_req;
  logic        in_req2;
  logic [1:0]  in_ep;
  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready, ch_ready2;
  logic        tx_valid, tx_valid2;
  logic [7:0]  tx_data, tx_data2;
  logic        tx_ready;
  logic        tx_eop, tx_eop2;
  logic        tx_nak, tx_nak2;
  logic        busy, busy2;
  logic [3:0]  zlp_pend, zlp_pend2;

  cdc_in_scheduler #(.NUM_CH(4), .MAX_PKT(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_ep(in_ep),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_eop(tx_eop), .tx_nak(tx_nak), .busy(busy), .zlp_pend(zlp_pend)
  );

  cdc_in_scheduler #(.NUM_CH(2), .MAX_PKT(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_req(in_req2), .in_ep(in_ep),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready2),
    .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready),
    .tx_eop(tx_eop2), .tx_nak(tx_nak2), .busy(busy2), .zlp_pend(zlp_pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       nak;
    int         len;
    logic [3:0] zlp;
  } ev_t;

  logic [7:0] fmem [4][256];
  int         rp [4];
  int         wp [4];
  logic [3:0] mzlp;
  logic [7:0] expq [$];
  ev_t        evq [$];
  int         cur_ch;
  int         pkt_len;
  logic [3:0] fire_r;
  logic       toggle;
  int         nchecks;
  int         nfail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      ch_valid[i]       = (wp[i] != rp[i]);
      ch_data[8*i +: 8] = fmem[i][rp[i] % 256];
    end
  endtask

  task automatic fill(input int ch, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[ch][wp[ch] % 256] = base + 8'(i);
      wp[ch]++;
    end
    refresh();
  endtask

  task automatic monitor();
    logic [3:0] oh, expf;
    ev_t        e;
    oh     = 4'b0001 << cur_ch;
    fire_r = ch_valid & ch_ready;
    expf   = (tx_valid && tx_ready) ? oh : 4'b0000;
    chk("pop_strobe", fire_r, expf);
    chk("ch_ready_other", ch_ready & ~oh, 0);
    chk("eop_nak_excl", tx_eop & tx_nak, 0);
    if (busy && tx_valid) chk("ch_ready_sel", ch_ready[cur_ch], tx_ready);
    if (tx_valid && tx_ready) begin
      chk("byte_expected", expq.size() != 0, 1);
      if (expq.size() != 0) chk("tx_data", tx_data, expq.pop_front());
      pkt_len++;
    end
    if (tx_eop || tx_nak) begin
      chk("event_expected", evq.size() != 0, 1);
      if (evq.size() != 0) begin
        e = evq.pop_front();
        chk("event_kind", tx_nak, e.nak);
        if (!e.nak) begin
          chk("pkt_len", pkt_len, e.len);
          chk("zlp_pend", zlp_pend, e.zlp);
        end
      end
      pkt_len = 0;
    end
  endtask

  task automatic edge_phase();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fire_r[i]) rp[i]++;
    fire_r  = 4'd0;
    in_req  = 1'b0;
    in_req2 = 1'b0;
    if (toggle) tx_ready = ~tx_ready;
    refresh();
  endtask

  task automatic tick();
    edge_phase();
    @(negedge clk);
    monitor();
  endtask

  task automatic raw_req(input int ch);
    in_req = 1'b1;
    in_ep  = 2'(ch);
    tick();
  endtask

  // Reference behaviour of one IN token against the bench FIFO contents.
  task automatic token(input int ch);
    int  avail, len;
    ev_t e;
    avail = wp[ch] - rp[ch];
    if (avail > 0) begin
      len = (avail > 64) ? 64 : avail;
      for (int i = 0; i < len; i++) expq.push_back(fmem[ch][(rp[ch] + i) % 256]);
      mzlp[ch] = (len == 64);
      e = '{nak: 1'b0, len: len, zlp: mzlp};
    end else if (mzlp[ch]) begin
      mzlp[ch] = 1'b0;
      e = '{nak: 1'b0, len: 0, zlp: mzlp};
    end else begin
      e = '{nak: 1'b1, len: 0, zlp: 4'd0};
    end
    evq.push_back(e);
    cur_ch = ch;
    raw_req(ch);
    chk("token_latency", tx_valid | tx_eop | tx_nak, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((evq.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_in_time", n < 2000, 1);
    chk("bytes_left", expq.size(), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_req = 1'b0; in_req2 = 1'b0; in_ep = 2'd0;
    tx_ready = 1'b0; toggle = 1'b0; ch_valid = 4'd0; ch_data = 32'd0;
    for (int i = 0; i < 4; i++) begin rp[i] = 0; wp[i] = 0; end
    mzlp = 4'd0; cur_ch = 0; pkt_len = 0; fire_r = 4'd0; nchecks = 0; nfail = 0;

    // Reset holds every output low even with data and a token present.
    fill(1, 3, 8'hA1);
    in_req = 1'b1; in_ep = 2'd1; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_valid, tx_data, tx_eop, tx_nak, busy, ch_ready, zlp_pend}, 0);
    in_req = 1'b0;
    rst_n  = 1'b1;

    token(1); drain();                       // short 3-byte packet
    fill(0, 70, 8'h00);
    token(0); drain();                       // full 64, ZLP owed
    token(0); drain();                       // 6-byte remainder
    fill(2, 64, 8'h40);
    token(2); drain();                       // exact 64
    token(2); drain();                       // ZLP
    token(2); drain();                       // NAK
    token(3); drain();                       // empty channel NAK

    // Narrow instance: in_ep beyond NUM_CH NAKs even with data waiting.
    fill(3, 1, 8'hC0);
    in_req2 = 1'b1; in_ep = 2'd3;
    tick();
    chk("nak2_pulse", tx_nak2, 1);
    chk("nak2_no_pop", {ch_ready2, tx_valid2, tx_eop2}, 0);
    tick();
    chk("nak2_one_cycle", {tx_nak2, busy2}, 0);

    // Backpressure toggling with a stray token mid-packet.
    fill(3, 19, 8'hC1);
    fill(0, 2, 8'hE0);
    toggle = 1'b1;
    token(3);
    repeat (5) tick();
    raw_req(0);
    drain();
    toggle = 1'b0; tx_ready = 1'b1;
    token(0); drain();

    fill(0, 64, 8'h10);
    token(0); drain();

    // Reset after 10 bytes of a 64-byte packet.
    fill(1, 64, 8'h80);
    for (int i = 0; i < 10; i++) expq.push_back(fmem[1][(rp[1] + i) % 256]);
    cur_ch = 1;
    raw_req(1);
    n = 0;
    while (pkt_len < 10 && n < 100) begin tick(); n++; end
    chk("ten_bytes_in_time", n < 100, 1);
    edge_phase();
    rst_n = 1'b0;
    #1;
    chk("midpkt_reset_outputs", {tx_valid, tx_data, tx_eop, tx_nak, busy, ch_ready, zlp_pend}, 0);
    @(negedge clk); monitor();
    tick();
    rst_n = 1'b1;
    pkt_len = 0; mzlp = 4'd0;
    chk("reset_no_leftover", expq.size(), 0);
    fill(1, 10, 8'hF0);
    token(1); drain();                       // restarts from zero: full 64
    repeat (3) tick();
    chk("idle_at_end", {busy, evq.size() != 0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
